leitor_7_segmentos: RTL and testbench

//  Reverse path of the binary->7-segment decoder: samples a 7-segment pattern
//  (e.g. from a display bus or a peer board) and recovers the 4-bit value.
//  A stability filter rejects glitches between patterns. Each accepted digit
//  is delivered once through a valid/ready handshake. Sits between the

---
 rtl/leitor_7_segmentos.sv | 151 +++++++++++++++
 tb/tb_leitor_7_segmentos.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/leitor_7_segmentos.sv
`default_nettype none
// ============================================================================
//  Module   : leitor_7_segmentos
//  Purpose  : Recovers a 4-bit digit from a 7-segment pattern, with a
//             stability filter and a valid/ready output handshake.
//             Optional macro HEX_EN adds the A..F patterns (10..15).
//  Revision : 1.0 - initial release
// ============================================================================
module leitor_7_segmentos #(
    parameter int STABLE_CYCLES   = 4,
    parameter bit SEG_ATIVO_BAIXO = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [0:6] segmentos,
    output logic [3:0] bin,
    output logic       valido,
    input  logic       pronto,
    output logic       erro,
    output logic       overrun,
    output logic [7:0] contador
);

    localparam int CNT_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_alvo   = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] c_um     = CNT_W'(1);
    localparam logic [0:6]       c_branco = 7'b0000000;

    typedef enum logic [0:0] {
        FILTRANDO = 1'b0,
        TRAVADO   = 1'b1
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [0:6]       amostra_q, amostra_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bin_q, bin_d;
    logic             valido_q, valido_d;
    logic             erro_q, erro_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       contador_q, contador_d;

    logic [0:6]       w_seg;
    logic             w_branco;
    logic             w_dig_ok;
    logic [3:0]       w_dig_val;
    logic             w_mudou;
    logic             w_aceita;

    // Normalise polarity so every comparison below is active-high.
    assign w_seg    = SEG_ATIVO_BAIXO ? ~segmentos : segmentos;
    assign w_branco = (w_seg == c_branco);

    always_comb begin
        w_dig_ok  = 1'b1;
        w_dig_val = 4'd0;
        case (w_seg)
            7'b1111110: w_dig_val = 4'd0;
            7'b0110000: w_dig_val = 4'd1;
            7'b1101101: w_dig_val = 4'd2;
            7'b1111001: w_dig_val = 4'd3;
            7'b0110011: w_dig_val = 4'd4;
            7'b1011011: w_dig_val = 4'd5;
            7'b1011111: w_dig_val = 4'd6;
            7'b1110000: w_dig_val = 4'd7;
            7'b1111111: w_dig_val = 4'd8;
            7'b1111011: w_dig_val = 4'd9;
`ifdef HEX_EN
            7'b1110111: w_dig_val = 4'd10;
            7'b0011111: w_dig_val = 4'd11;
            7'b1001110: w_dig_val = 4'd12;
            7'b0111101: w_dig_val = 4'd13;
            7'b1001111: w_dig_val = 4'd14;
            7'b1000111: w_dig_val = 4'd15;
`endif
            default:    w_dig_ok  = 1'b0;
        endcase
    end

    always_comb begin
        estado_d   = estado_q;
        amostra_d  = amostra_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        valido_d   = valido_q & ~pronto;
        erro_d     = erro_q;
        overrun_d  = overrun_q;
        contador_d = contador_q;
        w_mudou    = (w_seg != amostra_q);
        w_aceita   = 1'b0;

        // A change always restarts the run. With a one-cycle filter the
        // loading edge is also the accepting edge, from either state.
        if (w_mudou) begin
            amostra_d = w_seg;
            cnt_d     = c_um;
            estado_d  = FILTRANDO;
            w_aceita  = (c_alvo == c_um);
        end else if (estado_q == FILTRANDO) begin
            cnt_d    = cnt_q + c_um;
            w_aceita = ((cnt_q + c_um) == c_alvo);
        end

        if (w_aceita) begin
            estado_d = TRAVADO;
            if (!w_branco) begin
                if (w_dig_ok) begin
                    bin_d      = w_dig_val;
                    valido_d   = 1'b1;
                    erro_d     = 1'b0;
                    contador_d = contador_q + 8'd1;
                    if (valido_q && !pronto) begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    erro_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= FILTRANDO;
            amostra_q  <= c_branco;
            cnt_q      <= '0;
            bin_q      <= 4'd0;
            valido_q   <= 1'b0;
            erro_q     <= 1'b0;
            overrun_q  <= 1'b0;
            contador_q <= 8'd0;
        end else begin
            estado_q   <= estado_d;
            amostra_q  <= amostra_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            valido_q   <= valido_d;
            erro_q     <= erro_d;
            overrun_q  <= overrun_d;
            contador_q <= contador_d;
        end
    end

    assign bin      = bin_q;
    assign valido   = valido_q;
    assign erro     = erro_q;
    assign overrun  = overrun_q;
    assign contador = contador_q;

endmodule
`default_nettype wire

// File: tb/tb_leitor_7_segmentos.sv
`default_nettype none
// ============================================================================
//  Module   : tb_leitor_7_segmentos
//  Purpose  : Scoreboard bench for leitor_7_segmentos (active-high and
//             active-low instances fed the same pattern stream).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_leitor_7_segmentos;

    localparam int S = 4;
`ifdef HEX_EN
    localparam int N_DIG = 16;
`else
    localparam int N_DIG = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pronto = 1'b1;
    logic [0:6] seg = 7'b0;
    logic [0:6] seg_n;
    logic [3:0] bin0, bin1;
    logic       valido0, valido1, erro0, erro1, overrun0, overrun1;
    logic [7:0] contador0, contador1;

    assign seg_n = ~seg;

    leitor_7_segmentos #(.STABLE_CYCLES(S), .SEG_ATIVO_BAIXO(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .segmentos(seg), .bin(bin0), .valido(valido0),
        .pronto(pronto), .erro(erro0), .overrun(overrun0), .contador(contador0)
    );

    leitor_7_segmentos #(.STABLE_CYCLES(S), .SEG_ATIVO_BAIXO(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .segmentos(seg_n), .bin(bin1), .valido(valido1),
        .pronto(pronto), .erro(erro1), .overrun(overrun1), .contador(contador1)
    );

    always #5 clk = ~clk;

    // Segment patterns a..g, a in the MSB; index = digit value.
    logic [6:0] tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    typedef struct {
        int val;
        int edge_e;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_n   = 0;
    int   exp_cnt  = 0;
    int   exp_erro = 0;
    bit   sb_on    = 1'b0;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic void chk(string name, int act, int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // -1 blank, -2 not a digit, otherwise the digit value.
    function automatic int classify(logic [6:0] p);
        if (p == 7'b0) return -1;
        for (int i = 0; i < N_DIG; i++) begin
            if (tab[i] == p) return i;
        end
        return -2;
    endfunction

    // Holds pattern p for n edges, starting 2 units after a rising edge.
    task automatic drive_seg(input logic [6:0] p, input int n, input bit push);
        int c;
        int e0;
        c    = classify(p);
        e0   = edge_n;
        seg  = p;
        if (push && n >= S) begin
            if (c >= 0) begin
                exp_cnt  = (exp_cnt + 1) % 256;
                exp_erro = 0;
                q.push_back('{c, e0 + S, exp_cnt});
            end else if (c == -2) begin
                exp_erro = 1;
            end
        end
        repeat (n) @(posedge clk);
        #2;
        if (push) begin
            chk("erro", int'(erro0), exp_erro);
            chk("erro_inv", int'(erro1), exp_erro);
        end
    endtask

    task automatic do_reset();
        sb_on  = 1'b0;
        rst_n  = 1'b0;
        seg    = 7'b0;
        pronto = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n    = 1'b1;
        exp_cnt  = 0;
        exp_erro = 0;
        q.delete();
    endtask

    always @(negedge clk) begin
        if (sb_on && rst_n && valido0) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valido: got bin %0d expected no output (t=%0t)", bin0, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("bin", int'(bin0), e.val);
                chk("latency_edge", edge_n, e.edge_e);
                chk("contador", int'(contador0), e.cnt);
                chk("valido_inv", int'(valido1), 1);
                chk("bin_inv", int'(bin1), e.val);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] p, prev;
        int r;

        // Reset state while held in reset
        @(posedge clk); #2;
        chk("rst_bin", int'(bin0), 0);
        chk("rst_valido", int'(valido0), 0);
        chk("rst_erro", int'(erro0), 0);
        chk("rst_overrun", int'(overrun0), 0);
        chk("rst_contador", int'(contador0), 0);
        chk("rst_valido_inv", int'(valido1), 0);

        // Digits 0..9 in order
        do_reset();
        sb_on = 1'b1;
        for (int d = 0; d < 10; d++) drive_seg(tab[d], 6, 1'b1);
        chk("t1_contador", int'(contador0), 10);
        chk("t1_erro", int'(erro0), 0);
        chk("t1_pending", q.size(), 0);

        // Short glitch of "5" then "8"
        drive_seg(tab[5], 3, 1'b1);
        drive_seg(tab[8], 4, 1'b1);
        drive_seg(tab[8], 2, 1'b1);
        chk("t2_pending", q.size(), 0);

        // Overrun
        do_reset();
        pronto = 1'b0;
        drive_seg(tab[3], 6, 1'b0);
        chk("t3_valido_3", int'(valido0), 1);
        chk("t3_overrun_0", int'(overrun0), 0);
        drive_seg(tab[7], 6, 1'b0);
        chk("t3_valido", int'(valido0), 1);
        chk("t3_bin", int'(bin0), 7);
        chk("t3_overrun", int'(overrun0), 1);
        chk("t3_contador", int'(contador0), 2);
        pronto = 1'b1;
        @(posedge clk); #2;
        pronto = 1'b0;
        chk("t3_valido_clr", int'(valido0), 0);
        chk("t3_overrun_sticky", int'(overrun0), 1);

        // Accept on the same edge as consume: no overrun
        do_reset();
        pronto = 1'b0;
        drive_seg(tab[1], 6, 1'b0);
        drive_seg(tab[6], 3, 1'b0);
        pronto = 1'b1;
        drive_seg(tab[6], 1, 1'b0);
        chk("t3b_valido", int'(valido0), 1);
        chk("t3b_bin", int'(bin0), 6);
        chk("t3b_overrun", int'(overrun0), 0);

        // "E" pattern
        do_reset();
        sb_on = 1'b1;
        drive_seg(tab[14], 6, 1'b1);
`ifdef HEX_EN
        chk("t4_contador", int'(contador0), 1);
`else
        chk("t4_contador", int'(contador0), 0);
        chk("t4_valido", int'(valido0), 0);
`endif
        chk("t4_pending", q.size(), 0);

        // Asynchronous reset mid-filter with an unconsumed digit
        do_reset();
        pronto = 1'b0;
        drive_seg(tab[4], 6, 1'b0);
        chk("t5_valido_pre", int'(valido0), 1);
        drive_seg(tab[2], 2, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_bin", int'(bin0), 0);
        chk("t5_rst_valido", int'(valido0), 0);
        chk("t5_rst_contador", int'(contador0), 0);
        @(posedge clk); #2;
        rst_n  = 1'b1;
        pronto = 1'b1;
        repeat (3) @(posedge clk); #2;
        chk("t5_valido_early", int'(valido0), 0);
        @(posedge clk); #2;
        chk("t5_valido", int'(valido0), 1);
        chk("t5_bin", int'(bin0), 2);

        // Randomised pattern stream
        do_reset();
        sb_on = 1'b1;
        prev  = 7'b0;
        for (int k = 0; k < 150; k++) begin
            do begin
                r = $urandom_range(0, 99);
                if (r < 65)      p = tab[$urandom_range(0, 15)];
                else if (r < 85) p = 7'($urandom);
                else             p = 7'b0;
            end while (p == prev);
            drive_seg(p, $urandom_range(1, 8), 1'b1);
            prev = p;
        end
        p = (prev == tab[0]) ? tab[1] : tab[0];
        drive_seg(p, 10, 1'b1);
        sb_on = 1'b0;
        chk("rand_pending", q.size(), 0);
        chk("rand_contador", int'(contador0), exp_cnt);
        chk("rand_contador_inv", int'(contador1), exp_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
